// File: rtl/stats_sweeper_avlstrm.sv
`default_nettype none
// ============================================================================
// Module   : stats_sweeper_avlstrm
// Brief    : Snapshots NUM_STATS {addr,val} counters and streams each used
//            entry as a single-beat Avalon-ST packet. Optional: STATS_DELTA_EN.
// Revision : 1.0 - initial release
// ============================================================================

module stats_sweeper_avlstrm #(
   parameter int                NUM_STATS   = 4,
   parameter int                ADDR_W      = 8,
   parameter int                VAL_W       = 32,
   parameter int                INTERVAL    = 1024,
   parameter logic [ADDR_W-1:0] UNUSED_ADDR = ADDR_W'(8'hFF)
) (
   input  logic                               Clk,
   input  logic                               Rst,
   input  logic [NUM_STATS-1:0][ADDR_W-1:0]   stat_addr,
   input  logic [NUM_STATS-1:0][VAL_W-1:0]    stat_val,
   input  logic                               sweep_req,
   output logic [ADDR_W+VAL_W-1:0]            stats_out_data,
   output logic                               stats_out_valid,
   input  logic                               stats_out_ready,
   output logic                               stats_out_sop,
   output logic                               stats_out_eop,
   output logic                               busy,
   output logic                               sweep_done,
   output logic [15:0]                        sweep_count
);

   localparam int                 c_IDX_W    = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
   localparam int                 c_TMR_W    = $clog2(INTERVAL);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_STATS - 1);
   localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(INTERVAL - 1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_SNAP = 2'd1;
   localparam logic [1:0] c_ST_SEND = 2'd2;

   logic [1:0]                       r_state;
   logic [1:0]                       w_state_nxt;
   logic [c_TMR_W-1:0]               r_timer;
   logic [c_IDX_W-1:0]               r_idx;
   logic                             r_pending;
   logic                             r_sweep_done;
   logic [15:0]                      r_sweep_count;
   logic [NUM_STATS-1:0][ADDR_W-1:0] r_shadow_addr;
   logic [NUM_STATS-1:0][VAL_W-1:0]  r_shadow_val;

   logic [ADDR_W-1:0] w_cur_addr;
   logic [VAL_W-1:0]  w_cur_val;
   logic              w_skip;
   logic              w_in_send;
   logic              w_valid;
   logic              w_fire;
   logic              w_adv;
   logic              w_last;
   logic              w_trigger;

   assign w_cur_addr = r_shadow_addr[r_idx];
   assign w_cur_val  = r_shadow_val[r_idx];

`ifdef STATS_DELTA_EN
   logic [NUM_STATS-1:0][VAL_W-1:0] r_last_sent;
   logic [NUM_STATS-1:0]            r_sent_once;

   // An entry whose value has not moved since its last transfer is skipped like an unused one
   assign w_skip = (w_cur_addr == UNUSED_ADDR) ||
                   (r_sent_once[r_idx] && (w_cur_val == r_last_sent[r_idx]));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_last_sent <= '0;
         r_sent_once <= '0;
      end else if (w_fire) begin
         r_last_sent[r_idx] <= w_cur_val;
         r_sent_once[r_idx] <= 1'b1;
      end
   end
`else
   assign w_skip = (w_cur_addr == UNUSED_ADDR);
`endif

   assign w_in_send = (r_state == c_ST_SEND);
   assign w_valid   = w_in_send && !w_skip;
   assign w_fire    = w_valid && stats_out_ready;
   assign w_adv     = w_in_send && (w_skip || stats_out_ready);
   assign w_last    = w_adv && (r_idx == c_LAST_IDX);
   assign w_trigger = (r_timer == c_TMR_MAX) || sweep_req || r_pending;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (w_trigger) w_state_nxt = c_ST_SNAP;
         c_ST_SNAP: w_state_nxt = c_ST_SEND;
         c_ST_SEND: if (w_last) w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      busy            = (r_state != c_ST_IDLE);
      stats_out_valid = w_valid;
      stats_out_sop   = w_valid;
      stats_out_eop   = w_valid;
      stats_out_data  = w_valid ? {w_cur_addr, w_cur_val} : '0;
      sweep_done      = r_sweep_done;
      sweep_count     = r_sweep_count;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_timer       <= '0;
         r_idx         <= '0;
         r_pending     <= 1'b0;
         r_sweep_done  <= 1'b0;
         r_sweep_count <= '0;
         r_shadow_addr <= '0;
         r_shadow_val  <= '0;
      end else begin
         r_sweep_done <= w_last;
         if (w_last) begin
            r_sweep_count <= r_sweep_count + 16'd1;
         end

         // Timer is parked at zero while a sweep runs, so IDLE always restarts the interval from 0
         if (r_state != c_ST_IDLE) begin
            r_timer <= '0;
         end else if (r_timer != c_TMR_MAX) begin
            r_timer <= r_timer + 1'b1;
         end

         if ((r_state != c_ST_IDLE) && sweep_req) begin
            r_pending <= 1'b1;
         end else if ((r_state == c_ST_IDLE) && w_trigger) begin
            r_pending <= 1'b0;
         end

         if (r_state == c_ST_SNAP) begin
            r_shadow_addr <= stat_addr;
            r_shadow_val  <= stat_val;
            r_idx         <= '0;
         end else if (w_adv) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stats_sweeper_avlstrm.sv
`default_nettype none
// ============================================================================
// Module   : tb_stats_sweeper_avlstrm
// Brief    : Vector-table and directed-sequence bench for stats_sweeper_avlstrm.
// Revision : 1.0 - initial release
// ============================================================================

module tb_stats_sweeper_avlstrm;

   localparam int c_INTERVAL = 32;

   logic             Clk;
   logic             Rst;
   logic [3:0][7:0]  stat_addr;
   logic [3:0][31:0] stat_val;
   logic             sweep_req;
   logic [39:0]      data;
   logic             valid;
   logic             ready;
   logic             sop;
   logic             eop;
   logic             busy;
   logic             done;
   logic [15:0]      count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [39:0] q_beats[$];

   stats_sweeper_avlstrm #(
      .NUM_STATS (4),
      .ADDR_W    (8),
      .VAL_W     (32),
      .INTERVAL  (c_INTERVAL)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .stat_addr       (stat_addr),
      .stat_val        (stat_val),
      .sweep_req       (sweep_req),
      .stats_out_data  (data),
      .stats_out_valid (valid),
      .stats_out_ready (ready),
      .stats_out_sop   (sop),
      .stats_out_eop   (eop),
      .busy            (busy),
      .sweep_done      (done),
      .sweep_count     (count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (!Rst && valid && ready) q_beats.push_back(data);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        req;
      logic        rdy;
      logic [31:0] v1;
      logic        e_busy;
      logic        e_valid;
      logic [7:0]  e_addr;
      logic [31:0] e_val;
      logic        e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic req, input logic rdy, input logic [31:0] v1,
                               input logic b, input logic v, input logic [7:0] a,
                               input logic [31:0] val, input logic d, input logic [15:0] c);
      vec_t r;
      r.req = req; r.rdy = rdy; r.v1 = v1;
      r.e_busy = b; r.e_valid = v; r.e_addr = a; r.e_val = val; r.e_done = d; r.e_cnt = c;
      return r;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic eb, input logic ev, input logic [39:0] ed,
                      input logic edn, input logic [15:0] ec);
      n_tests++;
      if (busy !== eb || valid !== ev || sop !== ev || eop !== ev || done !== edn ||
          count !== ec || (ev && data !== ed)) begin
         n_fail++;
         $display("FAIL %s: got busy=%0b valid=%0b sop=%0b eop=%0b data=%h done=%0b count=%0d, expected busy=%0b valid=%0b data=%h done=%0b count=%0d",
                  nm, busy, valid, sop, eop, data, done, count, eb, ev, ed, edn, ec);
      end
   endtask

   task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_ticks(input string nm, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (busy !== 1'b0 || valid !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: got %0d of %0d cycles busy/valid, expected 0", nm, bad, n);
      end
   endtask

   task automatic wait_done(input string nm, input int max);
      int k = 0;
      while (done !== 1'b1 && k < max) begin
         tick();
         k++;
      end
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: got no sweep_done within %0d cycles, expected a pulse", nm, max);
      end
   endtask

   task automatic pulse_req();
      sweep_req = 1'b1;
      tick();
      sweep_req = 1'b0;
   endtask

   initial begin
      int base;
      int bad;
      logic [39:0] exp_beats[6];

      Rst       = 1'b1;
      sweep_req = 1'b0;
      ready     = 1'b1;
      stat_addr = {8'd4, 8'hFF, 8'd2, 8'd1};
      stat_val  = {32'd400, 32'd300, 32'd200, 32'd100};

      // Cycle-by-cycle vectors: inputs applied, one clock, then outputs compared.
      vt.push_back(mk(0, 1, 200, 1, 0, 0, 0,   0, 0));   // SNAP on timer expiry
      vt.push_back(mk(0, 1, 200, 1, 1, 1, 100, 0, 0));
      vt.push_back(mk(0, 1, 200, 1, 1, 2, 200, 0, 0));
      vt.push_back(mk(0, 1, 200, 1, 0, 0, 0,   0, 0));   // unused entry skipped
      vt.push_back(mk(0, 1, 200, 1, 1, 4, 400, 0, 0));
      vt.push_back(mk(0, 1, 200, 0, 0, 0, 0,   1, 1));
      vt.push_back(mk(0, 1, 200, 0, 0, 0, 0,   0, 1));
      for (int i = 0; i < 9; i++) vt.push_back(mk(0, 1, 200, 0, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 1, 200, 1, 0, 0, 0,   0, 1));   // request at timer=10
      vt.push_back(mk(0, 1, 200, 1, 1, 1, 100, 0, 1));
      vt.push_back(mk(0, 1, 999, 1, 1, 2, 200, 0, 1));   // live value changed
      for (int i = 0; i < 5; i++) vt.push_back(mk(0, 0, 999, 1, 1, 2, 200, 0, 1));
      vt.push_back(mk(0, 1, 999, 1, 0, 0, 0,   0, 1));
      vt.push_back(mk(0, 1, 999, 1, 1, 4, 400, 0, 1));
      vt.push_back(mk(0, 1, 999, 0, 0, 0, 0,   1, 2));
      vt.push_back(mk(0, 1, 999, 0, 0, 0, 0,   0, 2));

      tick();
      tick();
      chk("reset_state", 0, 0, '0, 0, 0);
      chk_val("reset_data", {24'd0, data}, 64'd0);
      Rst = 1'b0;

      idle_ticks("first_interval_idle", c_INTERVAL - 1);
      foreach (vt[i]) begin
         sweep_req    = vt[i].req;
         ready        = vt[i].rdy;
         stat_val[1]  = vt[i].v1;
         tick();
         chk($sformatf("vec%0d", i), vt[i].e_busy, vt[i].e_valid,
             {vt[i].e_addr, vt[i].e_val}, vt[i].e_done, vt[i].e_cnt);
      end
      sweep_req = 1'b0;
      ready     = 1'b1;

      exp_beats = '{{8'd1, 32'd100}, {8'd2, 32'd200}, {8'd4, 32'd400},
                    {8'd1, 32'd100}, {8'd2, 32'd200}, {8'd4, 32'd400}};
      chk_val("beat_count_ab", q_beats.size(), 6);
      bad = 0;
      for (int i = 0; i < 6 && i < q_beats.size(); i++) if (q_beats[i] !== exp_beats[i]) bad++;
      chk_val("beat_order_ab", bad, 0);

      // Two requests during SEND collapse into one follow-on sweep.
      base = q_beats.size();
      pulse_req();
      chk("req_snap", 1, 0, '0, 0, 2);
      tick();
      pulse_req();
      tick();
      pulse_req();
      wait_done("pending_first", 20);
      chk_val("pending_cnt1", count, 3);
      tick();
      chk("pending_snap", 1, 0, '0, 0, 3);
      wait_done("pending_second", 20);
      chk_val("pending_cnt2", count, 4);
      idle_ticks("no_third_sweep", 20);
      chk_val("pending_beats", q_beats.size() - base, 6);

      // Asynchronous reset while a beat is stalled.
      ready       = 1'b0;
      stat_val[1] = 200;
      pulse_req();
      tick();
      chk("stall_before_rst", 1, 1, {8'd1, 32'd100}, 0, 4);
      #2;
      Rst = 1'b1;
      #1;
      chk("rst_mid_beat", 0, 0, '0, 0, 0);
      tick();
      tick();
      Rst   = 1'b0;
      ready = 1'b1;
      base  = q_beats.size();
      idle_ticks("post_rst_idle", c_INTERVAL - 1);
      tick();
      chk("post_rst_snap", 1, 0, '0, 0, 0);
      tick();
      chk("post_rst_first", 1, 1, {8'd1, 32'd100}, 0, 0);
      wait_done("post_rst_done", 10);
      chk_val("post_rst_cnt", count, 1);
      chk_val("post_rst_beats", q_beats.size() - base, 3);
      tick();

      // All entries unused: four skip cycles, then the done pulse.
      stat_addr = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      base = q_beats.size();
      pulse_req();
      chk("unused_snap", 1, 0, '0, 0, 1);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (busy !== 1'b1 || valid !== 1'b0 || done !== 1'b0) bad++;
      end
      chk_val("unused_skip_cycles", bad, 0);
      tick();
      chk("unused_done", 0, 0, '0, 1, 2);
      chk_val("unused_no_beats", q_beats.size() - base, 0);

      // Repeat sweep after a value change on entry 1 only.
      Rst = 1'b1;
      tick();
      Rst       = 1'b0;
      stat_addr = {8'd4, 8'hFF, 8'd2, 8'd1};
      stat_val  = {32'd400, 32'd300, 32'd200, 32'd100};
      base = q_beats.size();
      pulse_req();
      wait_done("delta_sweep1", 20);
      chk_val("delta_sweep1_beats", q_beats.size() - base, 3);
      stat_val[1] = 201;
      tick();
      base = q_beats.size();
      pulse_req();
      wait_done("delta_sweep2", 20);
`ifdef STATS_DELTA_EN
      chk_val("delta_sweep2_beats", q_beats.size() - base, 1);
      if (q_beats.size() > base) chk_val("delta_sweep2_data", q_beats[base], {8'd2, 32'd201});
`else
      chk_val("delta_sweep2_beats", q_beats.size() - base, 3);
      if (q_beats.size() > base + 1) chk_val("delta_sweep2_data", q_beats[base + 1], {8'd2, 32'd201});
`endif
      chk_val("delta_cnt", count, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
